// File: rtl/pim_host_ctrl.sv
// pim_host_ctrl: host-side command sequencer for the PIM macro.
// Accepts one request at a time (req_valid/req_ready). It expands the request
// into single-cycle PIM commands and returns one response per request
// (rsp_valid/rsp_ready).
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req_*            request: cmd (WRITE/READ/OP/OP_RD/BLOCK_OP), alu select,
//                    addresses a/b/d, BLOCK_OP length, WRITE data
//   rsp_*            response: data (read value or element count), err flag
//   busy             sequencer not idle
//   pim_*            PIM command port (opcode, addresses, write data) and
//                    combinational read result
module pim_host_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_cmd,
  input  logic [1:0]            req_alu,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [ADDR_WIDTH-1:0] req_addr_d,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [2:0]            pim_opcode,
  output logic [ADDR_WIDTH-1:0] pim_addr_a,
  output logic [ADDR_WIDTH-1:0] pim_addr_b,
  output logic [ADDR_WIDTH-1:0] pim_addr_result,
  output logic [DATA_WIDTH-1:0] pim_write_data,
  input  logic [DATA_WIDTH-1:0] pim_result
);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_OP    = 3'b010;
  localparam logic [2:0] CMD_OP_RD = 3'b011;
  localparam logic [2:0] CMD_BLOCK = 3'b100;

  localparam logic [2:0] PIM_WRITE = 3'b100;
  localparam logic [2:0] PIM_READ  = 3'b111;
  localparam logic [2:0] PIM_NOP   = 3'b110;

  typedef enum logic [1:0] {IDLE, ISSUE, RDBK, RESP} state_t;

  state_t                state, state_nxt;
  logic                  fire;
  logic                  illegal;
  logic [LEN_WIDTH-1:0]  idx;

  // Request fields captured at the handshake.
  logic [2:0]            cmd_p0;
  logic [1:0]            alu_p0;
  logic [ADDR_WIDTH-1:0] addr_a_p0, addr_b_p0, addr_d_p0;
  logic [LEN_WIDTH-1:0]  len_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  last_elem;

  assign req_ready = (state == IDLE) && !rst;
  assign fire      = req_valid && req_ready;
  assign illegal   = (req_cmd > CMD_BLOCK);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  // READ reads its source address; OP_RD reads back the destination it just wrote.
  assign rd_addr   = (cmd_p0 == CMD_READ) ? addr_a_p0 : addr_d_p0;
  assign last_elem = (idx == len_p0 - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (fire) begin
      cmd_p0    <= req_cmd;
      alu_p0    <= req_alu;
      addr_a_p0 <= req_addr_a;
      addr_b_p0 <= req_addr_b;
      addr_d_p0 <= req_addr_d;
      len_p0    <= req_len;
      data_p0   <= req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE) idx <= idx + LEN_WIDTH'(1);
      else                idx <= '0;
      if (fire) begin
        rsp_err  <= illegal;
        rsp_data <= (req_cmd == CMD_BLOCK) ? DATA_WIDTH'(req_len) : '0;
      end else if (state == RDBK) begin
        rsp_data <= pim_result;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_err <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fire) begin
          if (illegal)                                     state_nxt = RESP;
          else if (req_cmd == CMD_READ)                    state_nxt = RDBK;
          else if ((req_cmd == CMD_BLOCK) && (req_len == '0)) state_nxt = RESP;
          else                                             state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_p0 == CMD_OP_RD)                     state_nxt = RDBK;
        else if ((cmd_p0 != CMD_BLOCK) || last_elem) state_nxt = RESP;
      end
      RDBK:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pim_opcode      = PIM_NOP;
    pim_addr_a      = '0;
    pim_addr_b      = '0;
    pim_addr_result = '0;
    pim_write_data  = '0;
    if (state == ISSUE) begin
      case (cmd_p0)
        CMD_WRITE: begin
          pim_opcode      = PIM_WRITE;
          pim_addr_result = addr_d_p0;
          pim_write_data  = data_p0;
        end
        CMD_BLOCK: begin
          // Element addresses wrap modulo the PIM address space.
          pim_opcode      = {1'b0, alu_p0};
          pim_addr_a      = addr_a_p0 + ADDR_WIDTH'(idx);
          pim_addr_b      = addr_b_p0 + ADDR_WIDTH'(idx);
          pim_addr_result = addr_d_p0 + ADDR_WIDTH'(idx);
        end
        default: begin
          pim_opcode      = {1'b0, alu_p0};
          pim_addr_a      = addr_a_p0;
          pim_addr_b      = addr_b_p0;
          pim_addr_result = addr_d_p0;
        end
      endcase
    end else if (state == RDBK) begin
      pim_opcode = PIM_READ;
      pim_addr_a = rd_addr;
    end
  end

endmodule

// File: tb/tb_pim_host_ctrl.sv
// tb_pim_host_ctrl: self-checking bench for pim_host_ctrl.
// Contains a PIM macro stand-in (memory + ALU) and a request-level reference
// model. The model predicts the per-cycle PIM command stream, the response
// and the memory contents.
module tb_pim_host_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk, rst;
  logic          req_valid, req_ready;
  logic [2:0]    req_cmd;
  logic [1:0]    req_alu;
  logic [AW-1:0] req_addr_a, req_addr_b, req_addr_d;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_data;
  logic [2:0]    pim_opcode;
  logic [AW-1:0] pim_addr_a, pim_addr_b, pim_addr_result;
  logic [DW-1:0] pim_write_data, pim_result;

  pim_host_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_alu(req_alu), .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .req_addr_d(req_addr_d), .req_len(req_len), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .pim_opcode(pim_opcode), .pim_addr_a(pim_addr_a), .pim_addr_b(pim_addr_b),
    .pim_addr_result(pim_addr_result), .pim_write_data(pim_write_data),
    .pim_result(pim_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [1:0] sel, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    case (sel)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x & y;
      default: return x ^ y;
    endcase
  endfunction

  // PIM macro stand-in.
  logic [DW-1:0] pim_mem [1024];
  logic          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) pim_mem[i] <= '0;
    end else if (pim_opcode[2] == 1'b0) begin
      pim_mem[pim_addr_result] <= alu_f(pim_opcode[1:0], pim_mem[pim_addr_a], pim_mem[pim_addr_b]);
    end else if (pim_opcode == 3'b100) begin
      pim_mem[pim_addr_result] <= pim_write_data;
    end
  end
  assign pim_result = (pim_opcode == 3'b111) ? pim_mem[pim_addr_a] : 32'hBAD0_BAD0;

  // Reference model state.
  logic [DW-1:0] ref_mem [1024];
  int n_chk, n_pass;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  function automatic logic [65:0] pack(input logic v, input logic [2:0] op, input logic [AW-1:0] a,
                                       input logic [AW-1:0] b, input logic [AW-1:0] d,
                                       input logic [DW-1:0] wd);
    return {v, op, a, b, d, wd};
  endfunction

  function automatic logic [65:0] obs_pack();
    return pack(rsp_valid, pim_opcode, pim_addr_a, pim_addr_b, pim_addr_result, pim_write_data);
  endfunction

  // One request end to end. Entered and left on a falling edge.
  // hold: cycles rsp_ready stays low in RESP; abort_at: element index at
  // which reset is applied (-1 = no reset).
  task automatic run_req(input logic [2:0] c, input logic [1:0] alu, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [AW-1:0] d, input logic [LW-1:0] len,
                         input logic [DW-1:0] data, input int hold, input int abort_at);
    logic [65:0]   q[$];
    logic [DW-1:0] rd;
    logic          err;
    logic [AW-1:0] ea, eb, ed;
    rd = '0; err = 1'b0;
    case (c)
      3'd0: begin q.push_back(pack(0, 3'b100, 0, 0, d, data)); ref_mem[d] = data; end
      3'd1: begin q.push_back(pack(0, 3'b111, a, 0, 0, 0)); rd = ref_mem[a]; end
      3'd2, 3'd3: begin
        q.push_back(pack(0, {1'b0, alu}, a, b, d, 0));
        ref_mem[d] = alu_f(alu, ref_mem[a], ref_mem[b]);
        if (c == 3'd3) begin q.push_back(pack(0, 3'b111, d, 0, 0, 0)); rd = ref_mem[d]; end
      end
      3'd4: begin
        for (int i = 0; i < int'(len); i++) begin
          ea = a + AW'(i); eb = b + AW'(i); ed = d + AW'(i);
          q.push_back(pack(0, {1'b0, alu}, ea, eb, ed, 0));
          if (abort_at < 0 || i < abort_at) ref_mem[ed] = alu_f(alu, ref_mem[ea], ref_mem[eb]);
        end
        rd = DW'(len);
      end
      default: err = 1'b1;
    endcase

    req_cmd = c; req_alu = alu; req_addr_a = a; req_addr_b = b; req_addr_d = d;
    req_len = len; req_data = data; req_valid = 1'b1;
    #1 chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_data = $urandom; req_addr_a = AW'($urandom); req_len = LW'($urandom);

    for (int k = 0; k < q.size(); k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        #1 chk("abort_outputs", {rsp_valid, req_ready, busy, pim_opcode}, {3'b000, 3'b110});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_rsp", {rsp_valid, busy, req_ready}, 3'b001);
        return;
      end
      chk($sformatf("issue_c%0d_k%0d", c, k), obs_pack(), q[k]);
      @(negedge clk);
    end

    chk($sformatf("rsp_c%0d", c), obs_pack(), pack(1, 3'b110, 0, 0, 0, 0));
    chk($sformatf("rsp_data_c%0d", c), rsp_data, rd);
    chk($sformatf("rsp_err_c%0d", c), rsp_err, err);

    // A competing request during RESP must be ignored.
    req_cmd = 3'd0; req_addr_d = AW'($urandom); req_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, req_ready, pim_opcode, rsp_err, rsp_data},
          {1'b1, 1'b0, 3'b110, err, rd});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {busy, rsp_valid, rsp_err, req_ready}, 4'b0001);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'(1016 + $urandom_range(0, 15));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int diffs;
    logic [2:0] c;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_cmd = '0; req_alu = '0; req_addr_a = '0; req_addr_b = '0;
    req_addr_d = '0; req_len = '0; req_data = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctrl", {rsp_valid, rsp_err, busy, req_ready}, 4'b0000);
    chk("reset_pim", obs_pack(), pack(0, 3'b110, 0, 0, 0, 0));
    chk("reset_rsp_data", rsp_data, 32'd0);
    mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_req(3'd0, 2'd0, 0, 0, 5, 0, 32'hDEADBEEF, 0, -1);
    run_req(3'd1, 2'd0, 5, 0, 0, 0, 0, 0, -1);
    run_req(3'd0, 2'd0, 0, 0, 1, 0, 32'd7, 0, -1);
    run_req(3'd0, 2'd0, 0, 0, 2, 0, 32'd3, 0, -1);
    run_req(3'd3, 2'd1, 1, 2, 9, 0, 0, 0, -1);
    run_req(3'd1, 2'd0, 9, 0, 0, 0, 0, 0, -1);
    run_req(3'd4, 2'd0, 1022, 0, 1020, 4, 0, 0, -1);
    run_req(3'd0, 2'd0, 0, 0, 33, 0, 32'h1234_5678, 5, -1);
    run_req(3'd5, 2'd2, 3, 4, 5, 6, 32'hFFFF_FFFF, 1, -1);
    run_req(3'd6, 2'd0, 0, 0, 0, 0, 0, 0, -1);
    run_req(3'd7, 2'd0, 0, 0, 0, 0, 0, 0, -1);
    run_req(3'd4, 2'd3, 7, 8, 9, 0, 0, 0, -1);
    for (int i = 0; i < 10; i++) run_req(3'd0, 2'd0, 0, 0, AW'(100 + i), 0, $urandom, 0, -1);
    run_req(3'd4, 2'd0, 100, 100, 300, 10, 0, 0, 3);

    for (int n = 0; n < 60; n++) begin
      c = 3'($urandom_range(0, 9));
      if (c > 3'd5 || n < 10) c = (n < 10) ? 3'd0 : 3'($urandom_range(0, 4));
      run_req(c, 2'($urandom), rnd_addr(), rnd_addr(), rnd_addr(), LW'($urandom_range(0, 12)),
              $urandom, $urandom_range(0, 3), -1);
    end

    diffs = 0;
    for (int i = 0; i < 1024; i++) if (pim_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_diff", diffs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pim_host_ctrl.md
# pim_host_ctrl

Host-side command sequencer that drives the PIM macro's command port (opcode, three addresses, write data) and collects its read result. It accepts one high-level request at a time over a valid/ready interface. Each request expands into one or more single-cycle PIM commands, and the block returns exactly one response per request over a second valid/ready interface. It sits between the system bus adapter and the PIM module.

## Interface
- DATA_WIDTH, 32, PIM word width
- ADDR_WIDTH, 10, PIM word address width
- LEN_WIDTH, 8, BLOCK_OP element-count width

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts request this cycle
- req_cmd  in  3  000 WRITE, 001 READ, 010 OP, 011 OP_RD, 100 BLOCK_OP, others illegal
- req_alu  in  2  ALU select for OP/OP_RD/BLOCK_OP
- req_addr_a, req_addr_b, req_addr_d  in  ADDR_WIDTH  source A, source B, destination
- req_len  in  LEN_WIDTH  BLOCK_OP element count
- req_data  in  DATA_WIDTH  WRITE data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_WIDTH  read data or element count
- rsp_err  out  1  illegal command
- busy  out  1  state != IDLE
- pim_opcode  out  3  PIM opcode: 000–011 compute (= {1'b0, alu}), 100 write, 111 read, 110 NOP
- pim_addr_a, pim_addr_b, pim_addr_result  out  ADDR_WIDTH  PIM addresses
- pim_write_data  out  DATA_WIDTH  PIM write data
- pim_result  in  DATA_WIDTH  PIM read port; valid combinationally while pim_opcode = 111

## Operation
- FSM states:
  - IDLE: req_ready = 1, all other outputs idle.
  - ISSUE: drive one write-type PIM command per cycle.
  - RDBK: drive pim_opcode = 111 with pim_addr_a = read address.
  - RESP: rsp_valid = 1.
- Handshake fires when req_valid & req_ready. All req_* fields are latched on that edge.
- Transitions out of IDLE:
  - READ → RDBK, address req_addr_a.
  - Illegal cmd → RESP, rsp_err = 1, rsp_data = 0.
  - BLOCK_OP with req_len = 0 → RESP, rsp_data = 0.
  - All other commands → ISSUE.
- ISSUE behaviour per command:
  - WRITE: pim_opcode = 100, pim_addr_result = addr_d, pim_write_data = data.
  - OP/OP_RD: pim_opcode = {0, alu}, addresses a, b, d.
  - BLOCK_OP: element counter idx runs 0..len−1, one element per cycle. Addresses are a+idx, b+idx, d+idx, each truncated to ADDR_WIDTH (wraps 1023 → 0).
- ISSUE exit:
  - OP_RD → RDBK with read address = addr_d.
  - Others → RESP. BLOCK_OP leaves after idx = len−1.
- RDBK: capture pim_result into rsp_data at the end of the cycle, then → RESP.
- RESP holds rsp_valid, rsp_data and rsp_err stable until rsp_ready. Then → IDLE, rsp_err cleared.
- rsp_data values:
  - WRITE/OP: 0.
  - READ/OP_RD: read value.
  - BLOCK_OP: len, zero-extended.
- Outside ISSUE/RDBK, the PIM outputs are: pim_opcode = 110, all addresses 0, write data 0.
- BLOCK_OP with overlapping ranges: elements are processed in ascending idx order. Each element sees all earlier writes.

## Timing
- Request accepted on the edge ending cycle T.
  - WRITE/OP: ISSUE in T+1 (SRAM written at end of T+1), rsp_valid from T+2.
  - READ: RDBK in T+1, rsp_valid from T+2.
  - OP_RD: ISSUE T+1, RDBK T+2, rsp_valid from T+3. Readback returns the value just written.
  - BLOCK_OP, len N: ISSUE T+1..T+N, rsp_valid from T+N+1.
- With rsp_ready held high, the response completes in its first RESP cycle. Next acceptance is possible one cycle later: WRITE peak rate is one per 3 cycles.
- req_ready is combinational from state: 0 in ISSUE/RDBK/RESP, and 0 while rst is high.
- Reset values (asynchronous, effective immediately):
  - State IDLE.
  - rsp_valid = 0, rsp_err = 0, rsp_data = 0, busy = 0.
  - pim_opcode = 110, PIM addresses/data = 0.
- Reset mid-operation aborts the request. PIM writes already completed remain in SRAM, and no response is produced.

## Test plan
- WRITE d=5, data 0xDEADBEEF, then READ a=5 → pim_opcode 100 in T+1; READ response rsp_data = 0xDEADBEEF two cycles after its acceptance.
- Preload [1]=7, [2]=3; OP_RD alu=01 (SUB), a=1, b=2, d=9 → rsp_data = 4 at T+3; later READ 9 = 4.
- BLOCK_OP len=4, a=1022, b=0, d=1020, alu=00 → four ISSUE cycles with pim_addr_a 1022, 1023, 0, 1; rsp_data = 4 at T+5.
- rsp_ready low for 5 cycles in RESP → rsp_valid/rsp_data stable, req_ready = 0, req_valid ignored; accepted on the cycle after rsp_ready rises.
- req_cmd = 101 → no PIM command (opcode stays 110), rsp_err = 1, rsp_data = 0; BLOCK_OP len=0 → rsp_data = 0, no PIM activity.
- rst asserted during BLOCK_OP len=10 at idx 3 → pim_opcode 110 immediately, elements 0–2 written, 3–9 untouched, no rsp_valid.
